// File: rtl/microwave_controller.sv
// Microwave sequencing controller: keypad digit entry into an m:ss time, 1 Hz countdown,
// start/stop/door interlock handling, and a timed cook-complete indication.
module microwave_controller #(
    parameter int DONE_TICKS = 3
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic [3:0] bcd_in,
    input  logic       loadn,
    input  logic       tick_1hz,
    input  logic       startn,
    input  logic       stopn,
    input  logic       door_closed,
    output logic       enablen,
    output logic       mag_on,
    output logic       done,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTING = 3'd1,
        COOKING = 3'd2,
        PAUSED  = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int CW = (DONE_TICKS < 2) ? 1 : $clog2(DONE_TICKS + 1);
    localparam logic [CW-1:0] DONE_LAST = CW'(DONE_TICKS - 1);

    state_t          state_reg;
    logic [3:0]      min_reg, tens_reg, ones_reg;
    logic [CW-1:0]   done_cnt_reg;
    logic            loadn_prev_reg, startn_prev_reg, stopn_prev_reg, tick_prev_reg;

    logic            load_ev, start_ev, stop_ev, tick_ev;
    logic            time_zero, digit_ok;
    logic [3:0]      min_dec, tens_dec, ones_dec;
    logic            dec_zero;

    assign load_ev  = loadn_prev_reg & ~loadn;
    assign start_ev = startn_prev_reg & ~startn;
    assign stop_ev  = stopn_prev_reg & ~stopn;
    assign tick_ev  = ~tick_prev_reg & tick_1hz;

    assign time_zero = (min_reg == 4'd0) && (tens_reg == 4'd0) && (ones_reg == 4'd0);
    // A shift that would push a digit above 5 into the seconds-tens place is refused outright.
    assign digit_ok  = load_ev && (bcd_in <= 4'd9) && (ones_reg <= 4'd5);

    always_comb begin
        min_dec  = min_reg;
        tens_dec = tens_reg;
        ones_dec = ones_reg;
        if (ones_reg != 4'd0) begin
            ones_dec = ones_reg - 4'd1;
        end else if (tens_reg != 4'd0) begin
            ones_dec = 4'd9;
            tens_dec = tens_reg - 4'd1;
        end else begin
            ones_dec = 4'd9;
            tens_dec = 4'd5;
            min_dec  = min_reg - 4'd1;
        end
    end

    assign dec_zero = (min_reg == 4'd0) && (tens_reg == 4'd0) && (ones_reg == 4'd1);

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            state_reg       <= IDLE;
            min_reg         <= 4'd0;
            tens_reg        <= 4'd0;
            ones_reg        <= 4'd0;
            done_cnt_reg    <= '0;
            loadn_prev_reg  <= 1'b1;
            startn_prev_reg <= 1'b1;
            stopn_prev_reg  <= 1'b1;
            tick_prev_reg   <= 1'b0;
        end else begin
            loadn_prev_reg  <= loadn;
            startn_prev_reg <= startn;
            stopn_prev_reg  <= stopn;
            tick_prev_reg   <= tick_1hz;
            case (state_reg)
                IDLE, SETTING: begin
                    if (stop_ev) begin
                        state_reg <= IDLE;
                        min_reg   <= 4'd0;
                        tens_reg  <= 4'd0;
                        ones_reg  <= 4'd0;
                    end else if (start_ev && door_closed && !time_zero) begin
                        state_reg <= COOKING;
                    end else if (digit_ok) begin
                        min_reg   <= tens_reg;
                        tens_reg  <= ones_reg;
                        ones_reg  <= bcd_in;
                        state_reg <= SETTING;
                    end
                end
                COOKING: begin
                    if (!door_closed || stop_ev) begin
                        state_reg <= PAUSED;
                    end else if (tick_ev) begin
                        min_reg  <= min_dec;
                        tens_reg <= tens_dec;
                        ones_reg <= ones_dec;
                        if (dec_zero) begin
                            state_reg    <= DONE;
                            done_cnt_reg <= '0;
                        end
                    end
                end
                PAUSED: begin
                    if (stop_ev) begin
                        state_reg <= IDLE;
                        min_reg   <= 4'd0;
                        tens_reg  <= 4'd0;
                        ones_reg  <= 4'd0;
                    end else if (start_ev && door_closed) begin
                        state_reg <= COOKING;
                    end
                end
                DONE: begin
                    if (stop_ev) begin
                        state_reg    <= IDLE;
                        done_cnt_reg <= '0;
                    end else if (tick_ev) begin
                        if (done_cnt_reg == DONE_LAST) begin
                            state_reg    <= IDLE;
                            done_cnt_reg <= '0;
                        end else begin
                            done_cnt_reg <= done_cnt_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Door interlock acts combinationally so the magnetron never waits for a clock edge.
    assign mag_on   = (state_reg == COOKING) && door_closed;
    assign enablen  = !((state_reg == IDLE) || (state_reg == SETTING));
    assign done     = (state_reg == DONE);
    assign min_ones = min_reg;
    assign sec_tens = tens_reg;
    assign sec_ones = ones_reg;
    assign state    = state_reg;
endmodule

// File: doc/microwave_controller.md
# microwave_controller

Sequencing controller for the microwave timer datapath. Consumes the keypad encoder's digit strobe (`BCD_OUT`/`loadn`) and the 1 Hz tick (`pgt_1hz`), builds an m:ss cook time, and gates the magnetron. It counts the time down and handles start, stop and door interlock. It also drives `enablen` back to the encoder, so the keypad only accepts digits while the oven is not cooking.

## Interface
Parameters:
- `DONE_TICKS`, default 3: number of 1 Hz ticks the `done` indicator is held after the count reaches 0:00.

Ports:
- `clk` in 1: system clock; all state changes on its rising edge.
- `clearn` in 1: asynchronous, active-low reset.
- `bcd_in` in 4: digit from the keypad encoder (`BCD_OUT`).
- `loadn` in 1: encoder digit-valid, active low; a digit is captured on the cycle a 1→0 transition is detected.
- `tick_1hz` in 1: 1 Hz timebase from `pgt_1hz`; one tick is counted per 0→1 transition.
- `startn` in 1: start button, active low; acts on the 1→0 edge.
- `stopn` in 1: stop/clear button, active low; acts on the 1→0 edge.
- `door_closed` in 1: level; 1 means the door is closed.
- `enablen` out 1: keypad enable to the encoder, active low.
- `mag_on` out 1: magnetron drive.
- `done` out 1: cook-complete indicator.
- `min_ones` out 4: minutes digit (BCD).
- `sec_tens` out 4: seconds-tens digit (BCD, 0–5).
- `sec_ones` out 4: seconds-ones digit (BCD).
- `state` out 3: FSM state code, for display and debug.

## Operation
State codes:
- IDLE = 0
- SETTING = 1
- COOKING = 2
- PAUSED = 3
- DONE = 4

Edge detection:
- Internal previous-value registers on `loadn`, `startn`, `stopn` and `tick_1hz`.
- All four previous-value registers reset to 1, except the `tick_1hz` register, which resets to 0.
- Each detected edge is a one-cycle event.

Digit entry (IDLE or SETTING only):
- On a `loadn` fall with `bcd_in` ≤ 9: shift left, i.e. `min_ones` ← `sec_tens`, `sec_tens` ← `sec_ones`, `sec_ones` ← `bcd_in`; then go to SETTING.
- Digits with `bcd_in` > 9 are ignored.
- If the shift would put a value > 5 into `sec_tens`, the whole shift is rejected and the digits are unchanged.

Event priority, applied per cycle, highest first:
1. Door open
2. Stop
3. Start
4. Tick
5. Digit

Transitions:
- IDLE or SETTING + start, with door closed and time ≠ 0:00 → COOKING. Start is ignored if the time is 0:00 or the door is open.
- SETTING + stop → IDLE, digits cleared to 0.
- COOKING + door open (`door_closed` = 0) → PAUSED.
- COOKING + stop → PAUSED.
- COOKING + tick: decrement the time.
  - If `sec_ones` > 0: decrement `sec_ones`.
  - Else if `sec_tens` > 0: `sec_ones` ← 9, decrement `sec_tens`.
  - Else: `sec_ones` ← 9, `sec_tens` ← 5, decrement `min_ones`.
  - If the result is 0:00 → DONE.
- PAUSED + start with door closed → COOKING, time retained.
- PAUSED + stop → IDLE, digits cleared.
- DONE: each tick increments an internal counter. When the counter reaches `DONE_TICKS` → IDLE.
- DONE + stop → IDLE immediately.
- Digits stay at 0 throughout DONE.

Outputs:
- `mag_on` = 1 only in COOKING, and only while `door_closed` = 1. It is combinationally forced low the same cycle the door opens.
- `enablen` = 0 in IDLE and SETTING; 1 otherwise.
- `done` = 1 only in DONE.

## Timing
Reset:
- While `clearn` = 0: state = IDLE; all digits = 0; `mag_on` = 0; `done` = 0; `enablen` = 0; DONE counter = 0.
- Reset takes effect immediately, including in the middle of COOKING, where `mag_on` drops without waiting for a clock edge.

Latency:
- Registered input edge to state/digit update: 1 cycle. The update is visible on the rising edge following the cycle in which the edge is detected.
- Final tick (0:01 → 0:00): digits read 0:00 and state = DONE on the same edge; `mag_on` falls on that edge.

Simultaneous events:
- Stop + start in the same cycle: stop wins.
- Tick + door open in COOKING: transition to PAUSED, no decrement.
- Tick + stop in COOKING: transition to PAUSED, no decrement.

Other rules:
- Ticks outside COOKING and DONE are ignored.
- `tick_1hz` pulses of any width count once.

## Test plan
- Reset, then digit entry 1, 3, 0 via `loadn` pulses, then start with door closed → digits 1:30, state COOKING, `mag_on` = 1, `enablen` = 1.
- From 1:00 in COOKING, one tick → 0:59; from 0:10, one tick → 0:09; from 0:01, one tick → 0:00, state DONE, `done` = 1, `mag_on` = 0. After 3 more ticks → IDLE, `done` = 0.
- At 0:45 in COOKING, drop `door_closed` → `mag_on` = 0 the same cycle, PAUSED; ticks leave 0:45; close door + start → COOKING, resumes from 0:45.
- Entry 0, 9 then 7 → the third shift is rejected (would set `sec_tens` = 9), digits stay 0:09. `bcd_in` = 12 is ignored. Start at 0:00 → stays IDLE.
- Stop and start asserted the same cycle in PAUSED → IDLE, digits 0:00. Stop in SETTING → IDLE, digits cleared.
- Assert `clearn` = 0 mid-COOKING at 2:17 → immediately IDLE, 0:00, `mag_on` = 0, `enablen` = 0.
